carrd_vissue_seq: RTL and testbench

- Parametrised in-order issue sequencer between the vector decoder and the vector execution units (valu/vmul lanes, vlsu, vsldu, vred).
- Replaces the current single-instruction, purely combinational dispatch with a QDEPTH-entry instruction queue, a dispatch FSM, per-FU done tracking, a watchdog timeout, flush, and a one-cycle writeback strobe.
- Only one vector instruction is in flight at a time, because all units share the op_A/op_B operand buses.

---
 rtl/carrd_vissue_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_carrd_vissue_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carrd_vissue_seq.sv
// carrd_vissue_seq: in-order vector issue sequencer.
// A QDEPTH-entry instruction queue feeds a four-state dispatch FSM that keeps
// a single instruction in flight at a time, because all units share the operand
// buses. The FSM waits for the selected FU's done pulse. If that pulse does not
// arrive, a watchdog aborts the instruction. A one-cycle writeback strobe follows
// completion when the instruction writes the register file. All outputs are
// registered.
module carrd_vissue_seq #(
    parameter int QDEPTH  = 4,
    parameter int NUM_FU  = 4,
    parameter int TIMEOUT = 256,
    parameter int FU_W    = $clog2(NUM_FU)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [31:0]              enq_instr,
    input  logic [FU_W-1:0]          enq_fu,
    input  logic [4:0]               enq_vd,
    input  logic                     enq_wb,
    output logic                     issue_valid,
    output logic [NUM_FU-1:0]        issue_fu,
    output logic [31:0]              issue_instr,
    input  logic [NUM_FU-1:0]        fu_done,
    output logic                     wb_en,
    output logic [4:0]               wb_vd,
    output logic                     busy,
    output logic [$clog2(QDEPTH):0]  q_count,
    output logic                     err_timeout
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    // Decode an FU index into the one-hot select driven to the units.
    function automatic logic [NUM_FU-1:0] fu_onehot(input logic [FU_W-1:0] idx);
        return NUM_FU'(1'b1) << idx;
    endfunction

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [31:0]          instr_mem_q [QDEPTH];
    logic [31:0]          instr_mem_d [QDEPTH];
    logic [FU_W-1:0]      fu_mem_q    [QDEPTH];
    logic [FU_W-1:0]      fu_mem_d    [QDEPTH];
    logic [4:0]           vd_mem_q    [QDEPTH];
    logic [4:0]           vd_mem_d    [QDEPTH];
    logic                 wb_mem_q    [QDEPTH];
    logic                 wb_mem_d    [QDEPTH];
    logic [31:0]          issue_instr_q, issue_instr_d;
    logic [NUM_FU-1:0]    issue_fu_q, issue_fu_d;
    logic [4:0]           vd_q, vd_d;
    logic                 wb_q, wb_d;
    logic [TO_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic                 issue_valid_q, issue_valid_d;
    logic                 wb_en_q, wb_en_d;
    logic [4:0]           wb_vd_q, wb_vd_d;
    logic                 busy_q, busy_d;
    logic                 enq_ready_q, enq_ready_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 push_s;
    logic                 pop_s;
    logic                 abort_s;
    logic                 done_hit_s;

    // Next-state logic for the dispatch FSM, queue, watchdog and registered outputs.
    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        instr_mem_d   = instr_mem_q;
        fu_mem_d      = fu_mem_q;
        vd_mem_d      = vd_mem_q;
        wb_mem_d      = wb_mem_q;
        issue_instr_d = issue_instr_q;
        issue_fu_d    = issue_fu_q;
        vd_d          = vd_q;
        wb_d          = wb_q;
        wd_cnt_d      = wd_cnt_q;
        pop_s         = 1'b0;
        abort_s       = 1'b0;
        // Only the selected unit's pulse counts; the select is zero outside ISSUE..WB.
        done_hit_s    = |(fu_done & issue_fu_q);
        // Full blocks enqueue even if a pop happens in the same cycle.
        push_s        = enq_valid && enq_ready_q && !flush;

        if (flush) begin
            state_d  = S_IDLE;
            wd_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != CNT_W'(0)) begin
                        pop_s         = 1'b1;
                        issue_instr_d = instr_mem_q[rd_ptr_q];
                        issue_fu_d    = fu_onehot(fu_mem_q[rd_ptr_q]);
                        vd_d          = vd_mem_q[rd_ptr_q];
                        wb_d          = wb_mem_q[rd_ptr_q];
                        state_d       = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    wd_cnt_d = '0;
                    state_d  = S_WAIT;
                end
                S_WAIT: begin
                    // A done pulse in the last watchdog cycle still completes normally.
                    if (done_hit_s) begin
                        state_d = wb_q ? S_WB : S_IDLE;
                    end else if (wd_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        abort_s = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wd_cnt_d = wd_cnt_q + TO_W'(1);
                    end
                end
                S_WB: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (push_s) begin
            instr_mem_d[wr_ptr_q] = enq_instr;
            fu_mem_d[wr_ptr_q]    = enq_fu;
            vd_mem_d[wr_ptr_q]    = enq_vd;
            wb_mem_d[wr_ptr_q]    = enq_wb;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end

        // The select and instruction are only presented while an instruction is in flight.
        if (state_d == S_IDLE) begin
            issue_instr_d = '0;
            issue_fu_d    = '0;
        end else begin
            issue_instr_d = issue_instr_d;
            issue_fu_d    = issue_fu_d;
        end

        issue_valid_d = (state_d == S_ISSUE);
        wb_en_d       = (state_d == S_WB);
        wb_vd_d       = (state_d == S_WB) ? vd_d : 5'd0;
        err_timeout_d = abort_s;
        busy_d        = (state_d != S_IDLE) || (count_d != CNT_W'(0));
        enq_ready_d   = (count_d != CNT_W'(QDEPTH));
    end

    // State, queue and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                instr_mem_q[i] <= '0;
                fu_mem_q[i]    <= '0;
                vd_mem_q[i]    <= '0;
                wb_mem_q[i]    <= 1'b0;
            end
            issue_instr_q <= '0;
            issue_fu_q    <= '0;
            vd_q          <= '0;
            wb_q          <= 1'b0;
            wd_cnt_q      <= '0;
            issue_valid_q <= 1'b0;
            wb_en_q       <= 1'b0;
            wb_vd_q       <= '0;
            busy_q        <= 1'b0;
            enq_ready_q   <= 1'b1;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            instr_mem_q   <= instr_mem_d;
            fu_mem_q      <= fu_mem_d;
            vd_mem_q      <= vd_mem_d;
            wb_mem_q      <= wb_mem_d;
            issue_instr_q <= issue_instr_d;
            issue_fu_q    <= issue_fu_d;
            vd_q          <= vd_d;
            wb_q          <= wb_d;
            wd_cnt_q      <= wd_cnt_d;
            issue_valid_q <= issue_valid_d;
            wb_en_q       <= wb_en_d;
            wb_vd_q       <= wb_vd_d;
            busy_q        <= busy_d;
            enq_ready_q   <= enq_ready_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign enq_ready   = enq_ready_q;
    assign issue_valid = issue_valid_q;
    assign issue_fu    = issue_fu_q;
    assign issue_instr = issue_instr_q;
    assign wb_en       = wb_en_q;
    assign wb_vd       = wb_vd_q;
    assign busy        = busy_q;
    assign q_count     = count_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_carrd_vissue_seq.sv
// Scoreboard bench for carrd_vissue_seq: the stimulus pushes expected issue,
// writeback and timeout events into queues, and a negedge monitor pops and
// compares them whenever the DUT pulses the corresponding output.
module tb_carrd_vissue_seq;

    localparam int QDEPTH  = 4;
    localparam int NUM_FU  = 4;
    localparam int TIMEOUT = 8;
    localparam int FU_W    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              enq_valid;
    logic              enq_ready;
    logic [31:0]       enq_instr;
    logic [FU_W-1:0]   enq_fu;
    logic [4:0]        enq_vd;
    logic              enq_wb;
    logic              issue_valid;
    logic [NUM_FU-1:0] issue_fu;
    logic [31:0]       issue_instr;
    logic [NUM_FU-1:0] fu_done;
    logic              wb_en;
    logic [4:0]        wb_vd;
    logic              busy;
    logic [2:0]        q_count;
    logic              err_timeout;

    carrd_vissue_seq #(.QDEPTH(QDEPTH), .NUM_FU(NUM_FU), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_instr(enq_instr),
        .enq_fu(enq_fu), .enq_vd(enq_vd), .enq_wb(enq_wb),
        .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_instr(issue_instr),
        .fu_done(fu_done), .wb_en(wb_en), .wb_vd(wb_vd), .busy(busy),
        .q_count(q_count), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0]       instr;
        logic [NUM_FU-1:0] fu_oh;
        int                cyc;
    } iss_t;
    typedef struct {
        logic [4:0] vd;
        int         cyc;
    } wb_t;

    iss_t exp_iss[$];
    wb_t  exp_wb[$];
    int   exp_err[$];
    iss_t mon_i;
    wb_t  mon_w;
    int   mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (issue_valid === 1'b1) begin
            chk("issue_pending", 64'(exp_iss.size() != 0), 64'd1);
            if (exp_iss.size() != 0) begin
                mon_i = exp_iss.pop_front();
                chk("issue_instr", issue_instr, mon_i.instr);
                chk("issue_fu", issue_fu, mon_i.fu_oh);
                if (mon_i.cyc >= 0) chk("issue_cycle", cyc, mon_i.cyc);
            end
        end
        if (wb_en === 1'b1) begin
            chk("wb_pending", 64'(exp_wb.size() != 0), 64'd1);
            if (exp_wb.size() != 0) begin
                mon_w = exp_wb.pop_front();
                chk("wb_vd", wb_vd, mon_w.vd);
                chk("wb_cycle", cyc, mon_w.cyc);
            end
        end
        if (err_timeout === 1'b1) begin
            chk("err_pending", 64'(exp_err.size() != 0), 64'd1);
            if (exp_err.size() != 0) begin
                mon_e = exp_err.pop_front();
                chk("err_cycle", cyc, mon_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] instr, input int fu, input int vd, input logic wb,
                       input bit expect_issue, input int icyc);
        iss_t e;
        enq_valid = 1'b1;
        enq_instr = instr;
        enq_fu    = fu[FU_W-1:0];
        enq_vd    = vd[4:0];
        enq_wb    = wb;
        if (expect_issue) begin
            e.instr = instr;
            e.fu_oh = 4'b0001 << fu;
            e.cyc   = icyc;
            exp_iss.push_back(e);
        end
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic wait_issue(output int icyc);
        icyc = -1;
        for (int k = 0; k < 40; k++) begin
            if (issue_valid === 1'b1) begin
                icyc = cyc;
                break;
            end
            tick();
        end
        chk("issue_seen", 64'(icyc >= 0), 64'd1);
    endtask

    task automatic done_now(input int fu, input logic wb, input int vd);
        wb_t w;
        fu_done = 4'b0001 << fu;
        if (wb) begin
            w.vd  = vd[4:0];
            w.cyc = cyc + 1;
            exp_wb.push_back(w);
        end
        tick();
        fu_done = 4'b0000;
    endtask

    task automatic complete(input int fu, input logic wb, input int vd, input int n);
        int ic;
        wait_issue(ic);
        repeat (n) tick();
        done_now(fu, wb, vd);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_q_count"}, q_count, 64'd0);
        chk({tag, "_enq_ready"}, enq_ready, 64'd1);
        chk({tag, "_busy"}, busy, 64'd0);
        chk({tag, "_outs_zero"}, {issue_valid, issue_fu, issue_instr, wb_en, wb_vd, err_timeout}, 64'd0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int ic;
        logic t2_wb [5];
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_instr = 32'd0;
        enq_fu = 2'd0; enq_vd = 5'd0; enq_wb = 1'b0; fu_done = 4'b0000;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Single op: issue two cycles after the enqueue call, wb one cycle after done.
        enq(32'h0000_0057, 0, 3, 1'b1, 1'b1, cyc + 2);
        complete(0, 1'b1, 3, 5);
        chk("t1_wb_en_now", wb_en, 64'd1);
        tick();
        chk("t1_busy_low", busy, 64'd0);
        chk("t1_q_count", q_count, 64'd0);

        // Fill: five accepted, sixth refused while full.
        for (int j = 0; j < 5; j++) begin
            t2_wb[j] = (j != 2);
            enq(32'h1000_0000 + 32'(j), j % 4, 10 + j, t2_wb[j], 1'b1, -1);
        end
        chk("t2_q_count_full", q_count, 64'd4);
        chk("t2_enq_ready_low", enq_ready, 64'd0);
        chk("t2_busy", busy, 64'd1);
        enq(32'hDEAD_0006, 1, 31, 1'b1, 1'b0, -1);
        chk("t2_sixth_refused", q_count, 64'd4);
        done_now(0, t2_wb[0], 10);
        for (int j = 1; j < 5; j++) complete(j % 4, t2_wb[j], 10 + j, 1);
        tick();
        chk("t2_drained", q_count, 64'd0);

        // Three further fills exercise pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 4; j++)
                enq(32'h2000_0000 + 32'(r * 16 + j), (j + r) % 4, r * 4 + j, 1'b1, 1'b1,
                    (j == 0) ? cyc + 2 : -1);
            chk("fill_q_count", q_count, 64'd3);
            done_now(r % 4, 1'b1, r * 4);
            for (int j = 1; j < 4; j++) complete((j + r) % 4, 1'b1, r * 4 + j, 1);
            tick();
        end
        chk("fill_empty", q_count, 64'd0);

        // Wrong / early done pulses are ignored.
        enq(32'h3000_0001, 1, 7, 1'b1, 1'b1, -1);
        wait_issue(ic);
        fu_done = 4'b0010;
        tick();
        fu_done = 4'b0100;
        tick();
        fu_done = 4'b0000;
        chk("t3_no_wb", wb_en, 64'd0);
        chk("t3_fu_held", issue_fu, 64'h2);
        repeat (2) tick();
        done_now(1, 1'b1, 7);
        tick();

        // Timeout: err_timeout 8 cycles after WAIT entry, then next instruction issues.
        enq(32'h4000_0001, 3, 9, 1'b1, 1'b1, -1);
        enq(32'h4000_0002, 2, 4, 1'b1, 1'b1, -1);
        wait_issue(ic);
        exp_err.push_back(ic + 9);
        tick();
        complete(2, 1'b1, 4, 2);
        tick();
        chk("t4_err_consumed", 64'(exp_err.size()), 64'd0);

        // Flush mid-WAIT with two queued and a simultaneous enqueue.
        enq(32'h5000_0001, 0, 1, 1'b1, 1'b1, -1);
        enq(32'h5000_0002, 1, 2, 1'b1, 1'b0, -1);
        enq(32'h5000_0003, 2, 3, 1'b1, 1'b0, -1);
        chk("t5_pre_q_count", q_count, 64'd2);
        flush = 1'b1;
        enq_valid = 1'b1; enq_instr = 32'h5000_00FF; enq_fu = 2'd3; enq_vd = 5'd5; enq_wb = 1'b1;
        tick();
        flush = 1'b0;
        enq_valid = 1'b0;
        fu_done = 4'b0001;
        chk("t5_q_count", q_count, 64'd0);
        chk("t5_busy", busy, 64'd0);
        chk("t5_fu_clear", issue_fu, 64'd0);
        chk("t5_enq_ready", enq_ready, 64'd1);
        tick();
        fu_done = 4'b0000;
        chk("t5_no_wb", wb_en, 64'd0);
        repeat (12) tick();
        chk("t5_still_empty", {busy, q_count}, 64'd0);

        // No-wb op, then reset during WAIT.
        enq(32'h6000_0001, 3, 8, 1'b0, 1'b1, -1);
        complete(3, 1'b0, 8, 2);
        chk("t6_no_wb", wb_en, 64'd0);
        chk("t6_idle", {busy, issue_fu}, 64'd0);
        enq(32'h6000_0002, 1, 12, 1'b1, 1'b1, -1);
        wait_issue(ic);
        tick();
        chk("t6_busy_wait", busy, 64'd1);
        rst = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0;
        fu_done = 4'b0010;
        tick();
        fu_done = 4'b0000;
        repeat (12) tick();
        check_reset("postrst");

        chk("sb_issue_empty", 64'(exp_iss.size()), 64'd0);
        chk("sb_wb_empty", 64'(exp_wb.size()), 64'd0);
        chk("sb_err_empty", 64'(exp_err.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
